// File: rtl/dff_deserializer_ctrl_pkg.sv
// Shared types for the serial-to-parallel flip-flop bank controller.
// Holds the FSM state encoding and the counter-width helper.
package dff_deserializer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Enough bits to hold any count from 0 up to width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dff_deserializer_ctrl_ff.sv
// Single D storage cell with asynchronous active-high clear and preset.
// Clear wins over preset; both win over the clocked D input.
module dff_deserializer_ctrl_ff (
  input  logic clk,
  input  logic clr,
  input  logic pr,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge clr or posedge pr) begin
    if (clr)     q <= 1'b0;
    else if (pr) q <= 1'b1;
    else         q <= d;
  end

endmodule

// File: rtl/dff_deserializer_ctrl.sv
// Shifts a serial bit stream into a bank of D cells and hands the full word
// out over a valid/ready handshake; clear/preset commands abort any word.
module dff_deserializer_ctrl
  import dff_deserializer_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          cmd_clr,
  input  logic                          cmd_pr,
  input  logic                          s_valid,
  input  logic                          s_bit,
  output logic                          s_ready,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [WIDTH-1:0]              m_data,
  output logic [cnt_width(WIDTH)-1:0]   bit_cnt,
  output logic                          busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [WIDTH-1:0]   q, d, shifted;
  logic               cmd, accept, cell_clr;

  assign cell_clr = ~clr_n;

  if (MSB_FIRST) begin : g_msb_first
    assign shifted = {q[WIDTH-2:0], s_bit};
  end else begin : g_lsb_first
    assign shifted = {s_bit, q[WIDTH-1:1]};
  end

  // Handshake outputs depend only on state and commands, never on s_valid/m_ready.
  always_comb begin
    cmd     = cmd_clr | cmd_pr;
    s_ready = (state != ST_FULL) && !cmd;
    m_valid = (state == ST_FULL) && !cmd;
    busy    = (state != ST_IDLE);
    accept  = s_valid && s_ready;
  end

  // NOTE: every signal gets a default before the branches so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    d         = q;
    if (cmd_clr) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      d         = '0;
    end else if (cmd_pr) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      d         = '1;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) begin
          d         = shifted;
          cnt_nxt   = CNT_W'(1);
          state_nxt = ST_SHIFT;
        end
        ST_SHIFT: if (accept) begin
          d       = shifted;
          cnt_nxt = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_nxt = ST_FULL;
        end
        ST_FULL: if (m_ready) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    dff_deserializer_ctrl_ff u_cell (
      .clk (clk),
      .clr (cell_clr),
      .pr  (1'b0),
      .d   (d[i]),
      .q   (q[i])
    );
  end

  assign m_data  = q;
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_dff_deserializer_ctrl.sv
// Bench for dff_deserializer_ctrl: MSB-first and LSB-first instances share
// stimulus and are compared every cycle against an arithmetic word model.
module tb_dff_deserializer_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr_n, cmd_clr, cmd_pr, s_valid, s_bit, m_ready;
  logic         s_ready_m, m_valid_m, busy_m;
  logic         s_ready_l, m_valid_l, busy_l;
  logic [W-1:0] m_data_m, m_data_l;
  logic [3:0]   bit_cnt_m, bit_cnt_l;

  int errors = 0;
  int checks = 0;

  // Reference: current word content per ordering, bits held, word-ready flag.
  int unsigned val_m, val_l;
  int          cnt;
  bit          full;
  int          transfers;

  always #5 clk = ~clk;

  dff_deserializer_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .clr_n(clr_n), .cmd_clr(cmd_clr), .cmd_pr(cmd_pr),
    .s_valid(s_valid), .s_bit(s_bit), .s_ready(s_ready_m),
    .m_valid(m_valid_m), .m_ready(m_ready), .m_data(m_data_m),
    .bit_cnt(bit_cnt_m), .busy(busy_m)
  );

  dff_deserializer_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clr_n(clr_n), .cmd_clr(cmd_clr), .cmd_pr(cmd_pr),
    .s_valid(s_valid), .s_bit(s_bit), .s_ready(s_ready_l),
    .m_valid(m_valid_l), .m_ready(m_ready), .m_data(m_data_l),
    .bit_cnt(bit_cnt_l), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    val_m = 0; val_l = 0; cnt = 0; full = 1'b0;
  endtask

  // Apply one cycle of inputs, compare outputs mid-cycle, then advance the model.
  task automatic step(input bit c, input bit p, input bit v, input bit b, input bit r);
    bit cmd;
    cmd_clr = c; cmd_pr = p; s_valid = v; s_bit = b; m_ready = r;
    cmd = c | p;
    @(negedge clk);
    check("s_ready_m", s_ready_m, !full && !cmd);
    check("s_ready_l", s_ready_l, !full && !cmd);
    check("m_valid_m", m_valid_m, full && !cmd);
    check("m_valid_l", m_valid_l, full && !cmd);
    check("busy_m",    busy_m,    full || cnt > 0);
    check("busy_l",    busy_l,    full || cnt > 0);
    check("bit_cnt_m", bit_cnt_m, cnt);
    check("bit_cnt_l", bit_cnt_l, cnt);
    check("m_data_m",  m_data_m,  val_m);
    check("m_data_l",  m_data_l,  val_l);
    if (c) begin
      val_m = 0; val_l = 0; cnt = 0; full = 1'b0;
    end else if (p) begin
      val_m = 255; val_l = 255; cnt = 0; full = 1'b0;
    end else if (full) begin
      if (r) begin
        transfers++;
        full = 1'b0;
        cnt  = 0;
      end
    end else if (v) begin
      val_m = (val_m * 2 + b) % 256;
      val_l = val_l / 2 + b * 128;
      cnt++;
      if (cnt == W) full = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] bits_in_order, input bit r);
    for (int i = 0; i < W; i++) step(0, 0, 1, bits_in_order[W-1-i], r);
  endtask

  initial begin
    int t0;
    clr_n = 1'b0; cmd_clr = 0; cmd_pr = 0; s_valid = 0; s_bit = 0; m_ready = 0;
    transfers = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_data", m_data_m, 8'h00);
    check("rst_bit_cnt", bit_cnt_m, 0);
    check("rst_m_valid", m_valid_m, 0);
    check("rst_busy", busy_m, 0);
    clr_n = 1'b1;
    #1;
    check("rst_s_ready", s_ready_m, 1);

    // Bit sequence 1,0,1,1,0,0,1,0 back-to-back with m_ready high.
    send_word(8'b1011_0010, 1'b1);
    check("word_msb", m_data_m, 8'hB2);
    check("word_lsb", m_data_l, 8'h4D);
    check("full_m_valid", m_valid_m, 1);
    check("full_s_ready", s_ready_m, 0);
    t0 = transfers;
    step(0, 0, 0, 0, 1);
    check("one_transfer", transfers - t0, 1);
    check("after_xfer_s_ready", s_ready_m, 1);
    check("after_xfer_m_valid", m_valid_m, 0);
    check("after_xfer_hold", m_data_m, 8'hB2);

    // Backpressure: all-ones word held for 5 cycles while s_valid stays high.
    send_word(8'hFF, 1'b0);
    repeat (5) step(0, 0, 1, 0, 0);
    check("bp_hold_data", m_data_m, 8'hFF);
    check("bp_hold_valid", m_valid_m, 1);
    t0 = transfers;
    step(0, 0, 1, 0, 1);
    check("bp_one_transfer", transfers - t0, 1);
    check("bp_s_ready_back", s_ready_m, 1);

    // Abort 3 bits in with both commands and a bit offered.
    step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 0); step(0, 0, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    check("abort_data", m_data_m, 8'h00);
    check("abort_cnt", bit_cnt_m, 0);
    check("abort_busy", busy_m, 0);

    // Preset while a full word is offered and m_ready is high.
    send_word(8'h5A, 1'b0);
    t0 = transfers;
    step(0, 1, 0, 0, 1);
    check("pr_full_data", m_data_m, 8'hFF);
    check("pr_full_valid", m_valid_m, 0);
    check("pr_no_transfer", transfers - t0, 0);

    // Asynchronous reset between edges, five bits into a word.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0);
    s_valid = 1'b0;
    #1 clr_n = 1'b0;
    #1;
    check("async_data", m_data_m, 8'h00);
    check("async_cnt", bit_cnt_m, 0);
    check("async_valid", m_valid_m, 0);
    check("async_busy", busy_m, 0);
    #1 clr_n = 1'b1;
    model_reset();
    send_word(8'hC3, 1'b1);
    check("fresh_word_msb", m_data_m, 8'hC3);
    check("fresh_word_lsb", m_data_l, 8'hC3);
    step(0, 0, 0, 0, 1);

    // Randomized traffic with occasional commands.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(31) == 0, $urandom_range(31) == 0,
           $urandom_range(9) < 7, $urandom_range(1) == 1,
           $urandom_range(1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dff_deserializer_ctrl.md
Name: dff_deserializer_ctrl

Overview:
- Sequencing controller for a WIDTH-bit bank of flipflopD storage cells.
- Accepts a serial bit stream over a valid/ready handshake and shifts it into the bank.
- Once a full word is captured, presents it as a parallel word over a second valid/ready handshake.
- Provides synchronous whole-bank clear and preset commands.
- Sits between a serial source (UART-style front end, test stimulus) and parallel consumers.

Parameters:
- WIDTH, 8, number of bits in the bank; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in m_data[WIDTH-1]; 0 = first received bit lands in m_data[0].

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- cmd_clr  input  1  synchronous clear of the whole bank; abort of any word in progress.
- cmd_pr  input  1  synchronous preset of the whole bank to all ones; abort of any word in progress.
- s_valid  input  1  serial bit valid.
- s_bit  input  1  serial data bit.
- s_ready  output  1  controller can accept a bit this cycle.
- m_valid  output  1  parallel word available.
- m_ready  input  1  consumer accepts the word.
- m_data  output  WIDTH  bank contents (Q outputs of the storage cells).
- bit_cnt  output  $clog2(WIDTH+1)  bits captured in the current word.
- busy  output  1  high in SHIFT or FULL.

Behaviour:
- Reset (clr_n low, asynchronous):
  - state = IDLE, m_data = 0, bit_cnt = 0, m_valid = 0, busy = 0.
  - s_ready = 1 once clr_n is high.
  - Reset is honoured mid-word and mid-output; the partial word is lost.
- FSM states: IDLE, SHIFT, FULL.
  - IDLE: s_ready = 1. Accepted bit (s_valid & s_ready) -> shift in, bit_cnt = 1, go to SHIFT.
  - SHIFT: s_ready = 1. Each accepted bit shifts in and increments bit_cnt. The accept that makes bit_cnt == WIDTH -> go to FULL on the same edge. Cycles with s_valid low leave everything unchanged (no timeout).
  - FULL: m_valid = 1, s_ready = 0, m_data held stable. On m_valid & m_ready -> IDLE, bit_cnt = 0, m_data retains the delivered word. s_ready returns high the cycle after the handshake; no same-cycle bypass.
- Latency:
  - m_valid rises on the same clock edge that captures the WIDTH-th bit.
  - Minimum word period is WIDTH+1 cycles with m_ready held high.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit enters bit 0.
  - MSB_FIRST=0: shift right, new bit enters bit WIDTH-1.
- Commands:
  - cmd_clr has priority over cmd_pr; either has priority over all handshakes.
  - Either command forces s_ready = 0 combinationally in the same cycle, so any bit presented that cycle is not accepted.
  - Next edge: m_data = 0 (cmd_clr) or all ones (cmd_pr); bit_cnt = 0; m_valid = 0; state = IDLE.
  - A command in FULL drops the pending word even when m_ready is high in the same cycle; no transfer counts.
- Storage:
  - m_data comes directly from the flipflopD Q outputs.
  - Cell D input = mux(command value, shifted value, hold).
  - Cell clr pin (active-high) is driven by ~clr_n; cell pr pin is tied to 0.
- Outputs s_ready, m_valid and busy are derived from state plus the command inputs only; there is no combinational path from s_valid or m_ready.
- bit_cnt never exceeds WIDTH.

Decomposition:
- Shared include header (dff_ctrl_defs.vh): state encodings (IDLE=2'd0, SHIFT=2'd1, FULL=2'd2) and the width of bit_cnt as a macro.
- One generate loop instantiating WIDTH flipflopD cells for storage.
- FSM, counter and next-D mux live in this module; no further sub-module.

Test Plan:
- Reset: clr_n low for 2 cycles, then high -> m_data=0, m_valid=0, s_ready=1, bit_cnt=0, busy=0.
- MSB_FIRST=1, WIDTH=8, bits 1,0,1,1,0,0,1,0 sent back-to-back, m_ready=1 -> m_data=8'hB2, m_valid high for exactly 1 cycle, s_ready low that cycle.
- MSB_FIRST=0, same bit sequence -> m_data=8'h4D.
- Backpressure: fill with 8'hFF, hold m_ready=0 for 5 cycles, drive s_valid=1 throughout -> m_valid stays 1, s_ready stays 0, m_data constant; raise m_ready -> one transfer, next cycle s_ready=1.
- Command abort: 3 bits into a word, assert cmd_pr and cmd_clr together for 1 cycle with s_valid=1 -> m_data=0, bit_cnt=0, no bit accepted, state IDLE. Repeat in FULL with m_ready=1 and cmd_pr only -> m_data=8'hFF, m_valid=0, no transfer.
- Async reset mid-word: after 5 bits, pulse clr_n low between clock edges -> outputs clear immediately without waiting for an edge; the next 8 bits form a fresh word.
